// File: rtl/ise_pixel_feeder_pkg.sv
// Shared types and defaults for the image sort engine pixel feeder.
package ise_pkg;
  localparam int IMG_NUM_DEF     = 32;
  localparam int PIX_PER_IMG_DEF = 16384;
  localparam int ADDR_W          = 19;
  localparam int IDX_W           = 5;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} feeder_state_t;
endpackage

// File: rtl/ise_pixel_feeder_if.sv
// Memory read port and pixel stream between the feeder and its neighbours.
interface ise_pixel_feeder_if import ise_pkg::*; #(
  parameter int DATA_W = 24
) ();
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              pixel_valid;
  logic [DATA_W-1:0] pixel_out;
  logic [IDX_W-1:0]  image_index_out;

  modport master (
    output mem_rd, mem_addr, pixel_valid, pixel_out, image_index_out,
    input  mem_rdata, busy
  );
  modport slave (
    input  mem_rd, mem_addr, pixel_valid, pixel_out, image_index_out,
    output mem_rdata, busy
  );
endinterface

// File: rtl/ise_pixel_feeder_skid_fifo2.sv
// 2-entry FIFO; when empty, a push is presented at the head in the same cycle
// so a simultaneous pop takes it straight through.
module ise_skid_fifo2 #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr, store, take;

  assign take  = pop && (count != 2'd0);
  assign store = push && !(pop && count == 2'd0);
  assign valid = (count != 2'd0) || push;
  assign head  = (count != 2'd0) ? mem[rd_ptr] : (push ? din : '0);

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) wr_ptr <= ~wr_ptr;
      if (take)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(store) - 2'(take);
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (reset) pop |-> valid);
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) push |-> (count != 2'd2));
endmodule

// File: rtl/ise_pixel_feeder.sv
// Streams IMG_NUM images from pixel memory, one pixel per cycle, under busy back-pressure.
// Optional per-image R+G+B checksum output: define ISE_FEEDER_CHKSUM_EN.
module ise_pixel_feeder
  import ise_pkg::*;
#(
  parameter int IMG_NUM     = IMG_NUM_DEF,
  parameter int PIX_PER_IMG = PIX_PER_IMG_DEF,
  parameter int DATA_W      = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  ise_pixel_feeder_if.master bus,
  output logic               done
`ifdef ISE_FEEDER_CHKSUM_EN
  ,
  output logic               chk_valid,
  output logic [31:0]        chk_sum
`endif
);
  localparam int                PIX_W     = $clog2(PIX_PER_IMG);
  localparam int                FW        = DATA_W + IDX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_NUM * PIX_PER_IMG - 1);

  feeder_state_t     state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_q;
  logic              inflight, rd, xfer, at_last;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [FW-1:0]     fifo_din, fifo_head;

  assign at_last = (addr == LAST_ADDR);
  assign xfer    = fifo_valid && !bus.busy;

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        // fifo entries plus the read in flight never exceed the 2 slots
        rd = (fifo_count + {1'b0, inflight}) < 2'd2;
        if (rd && at_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_count == 2'd0 && !inflight) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr     <= '0;
      addr_q   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd;
      if (rd) addr_q <= addr;
      if (state == ST_IDLE && start) addr <= '0;
      else if (rd && !at_last)       addr <= addr + 1'b1;
    end
  end

  assign fifo_din = {IDX_W'(addr_q >> PIX_W), bus.mem_rdata};

  ise_skid_fifo2 #(.W(FW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din   (fifo_din),
    .pop   (xfer),
    .count (fifo_count),
    .valid (fifo_valid),
    .head  (fifo_head)
  );

  assign bus.mem_rd      = rd;
  assign bus.mem_addr    = addr;
  assign bus.pixel_valid = fifo_valid;
  assign {bus.image_index_out, bus.pixel_out} = fifo_head;
  assign done            = (state == ST_DONE);

`ifdef ISE_FEEDER_CHKSUM_EN
  logic [PIX_W-1:0] pix_cnt;
  logic [31:0]      acc, acc_nxt;
  pixel_t           px;

  assign px      = pixel_t'(bus.pixel_out[23:0]);
  assign acc_nxt = acc + 32'(px.r) + 32'(px.g) + 32'(px.b);

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt   <= '0;
      acc       <= '0;
      chk_valid <= 1'b0;
      chk_sum   <= '0;
    end else begin
      chk_valid <= 1'b0;
      if (state == ST_IDLE && start) begin
        pix_cnt <= '0;
        acc     <= '0;
      end else if (xfer) begin
        pix_cnt <= pix_cnt + 1'b1;
        if (pix_cnt == PIX_W'(PIX_PER_IMG - 1)) begin
          chk_valid <= 1'b1;
          chk_sum   <= acc_nxt;
          acc       <= '0;
        end else begin
          acc <= acc_nxt;
        end
      end
    end
  end
`endif
endmodule
